// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// No logic: constants, the pipeline stage record and a width helper.
// Stage fields are sized for the largest supported configuration.
package mul_arb_pkg;

    localparam int MAX_N_REQ = 16;
    localparam int MAX_ID_W  = 4;
    localparam int MAX_MUL_W = 64;

    typedef struct packed {
        logic                 valid;
        logic [MAX_ID_W-1:0]  id;
        logic [MAX_MUL_W-1:0] prod;
    } stage_t;

    // Index width that never collapses to zero bits (N=2 still needs one bit).
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multiplier_wallace.sv
// Combinational multiplier, optionally signed, with optional low-column truncation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the product.
module multiplier_wallace #(
    parameter int IA_W        = 16,
    parameter int IB_W        = 16,
    parameter int SIGNED      = 0,
    parameter int APPROX_TYPE = 0
) (
    input  logic [IA_W-1:0]      i_a,
    input  logic [IB_W-1:0]      i_b,
    output logic [IA_W+IB_W-1:0] o_prod
);

    localparam int P_W = IA_W + IB_W;

    logic [P_W-1:0] w_a_ext;
    logic [P_W-1:0] w_b_ext;
    logic [P_W-1:0] w_full;
    logic [P_W-1:0] w_mask;

    // Extend operands to product width; the low P_W bits of the product are then
    // correct for both unsigned and two's-complement inputs.
    always_comb begin
        if (SIGNED != 0) begin
            w_a_ext = {{IB_W{i_a[IA_W-1]}}, i_a};
            w_b_ext = {{IA_W{i_b[IB_W-1]}}, i_b};
        end else begin
            w_a_ext = {{IB_W{1'b0}}, i_a};
            w_b_ext = {{IA_W{1'b0}}, i_b};
        end
    end

    // The partial-product reduction tree is left to the synthesis tool.
    assign w_full = w_a_ext * w_b_ext;

    // APPROX_TYPE>0 drops that many least-significant product columns.
    assign w_mask = {P_W{1'b1}} << APPROX_TYPE;
    assign o_prod = w_full & w_mask;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after the pointer wins.
// Latency: grant is combinational; pointer moves on the clock after an accept.
// Backpressure: no grant and pointer hold while i_advance is low.
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int ID_W = clog2_min1(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_valid,
    input  logic            i_advance,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_idx,
    output logic            o_any_valid
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_idx;
    logic            w_any;

    // Rotating search starting at the pointer, wrapping modulo N.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_any && i_valid[(int'(r_ptr) + i) % N]) begin
                w_any = 1'b1;
                w_idx = ID_W'((int'(r_ptr) + i) % N);
            end
        end
    end

    // One-hot grant only when the downstream pipeline can move.
    always_comb begin
        o_grant = '0;
        if (i_advance && w_any) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    assign o_grant_idx = w_idx;
    assign o_any_valid = w_any;

    // Pointer moves just past the winner on every accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_any) begin
            r_ptr <= (w_idx == ID_W'(N - 1)) ? '0 : w_idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multiplier among N_REQ requesters with round-robin issue, one op per cycle.
// Latency: exactly LATENCY cycles from accept to o_rsp_valid when not stalled.
// Backpressure: i_rsp_ready low with a valid result freezes every stage and blocks grants.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int IA_W        = 16,
    parameter  int IB_W        = 16,
    parameter  int MUL_W       = 32,
    parameter  int SIGNED      = 0,
    parameter  int APPROX_TYPE = 0,
    parameter  int LATENCY     = 2,
    localparam int ID_W        = clog2_min1(N_REQ),
    localparam int CNT_W       = clog2_min1(LATENCY + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ*IA_W-1:0] i_req_a,
    input  logic [N_REQ*IB_W-1:0] i_req_b,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic                  o_rsp_valid,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic [MUL_W-1:0]      o_rsp_prod,
    input  logic                  i_rsp_ready,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_inflight
);

    stage_t                r_stage [LATENCY];
    stage_t                w_unused_last;
    logic [CNT_W-1:0]      r_inflight;
    logic                  w_advance;
    logic                  w_grant_en;
    logic                  w_accept;
    logic                  w_rsp_fire;
    logic                  w_any;
    logic                  w_busy;
    logic [ID_W-1:0]       w_grant_idx;
    logic [IA_W-1:0]       w_sel_a;
    logic [IB_W-1:0]       w_sel_b;
    logic [IA_W+IB_W-1:0]  w_mul_prod;

    assign w_advance  = !o_rsp_valid || i_rsp_ready;
    // Grants are suppressed during reset so nothing is accepted into a clearing pipe.
    assign w_grant_en = w_advance && !i_rst;
    assign w_accept   = w_grant_en && w_any;
    assign w_rsp_fire = o_rsp_valid && i_rsp_ready;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_req_valid),
        .i_advance   (w_grant_en),
        .o_grant     (o_req_ready),
        .o_grant_idx (w_grant_idx),
        .o_any_valid (w_any)
    );

    // Operand mux selected by the winning requester index.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant_idx == ID_W'(k)) begin
                w_sel_a = i_req_a[k*IA_W +: IA_W];
                w_sel_b = i_req_b[k*IB_W +: IB_W];
            end
        end
    end

    multiplier_wallace #(
        .IA_W        (IA_W),
        .IB_W        (IB_W),
        .SIGNED      (SIGNED),
        .APPROX_TYPE (APPROX_TYPE)
    ) u_mul (
        .i_a    (w_sel_a),
        .i_b    (w_sel_b),
        .o_prod (w_mul_prod)
    );

    // Result pipeline: all stages shift together; bubbles travel as valid=0 entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < LATENCY; j++) begin
                r_stage[j] <= '0;
            end
        end else if (w_advance) begin
            r_stage[0].valid <= w_accept;
            r_stage[0].id    <= MAX_ID_W'(w_grant_idx);
            r_stage[0].prod  <= MAX_MUL_W'(w_mul_prod);
            for (int j = 1; j < LATENCY; j++) begin
                r_stage[j] <= r_stage[j-1];
            end
        end
    end

    // In-flight count: up on accept, down on result handshake, unchanged when both.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= '0;
        end else if (w_accept && !w_rsp_fire) begin
            r_inflight <= r_inflight + CNT_W'(1);
        end else if (!w_accept && w_rsp_fire) begin
            r_inflight <= r_inflight - CNT_W'(1);
        end
    end

    // Busy whenever any stage carries a real result.
    always_comb begin
        w_busy = 1'b0;
        for (int j = 0; j < LATENCY; j++) begin
            w_busy = w_busy | r_stage[j].valid;
        end
    end

    // Upper bits of the max-width record are zero-extension only.
    assign w_unused_last = r_stage[LATENCY-1];

    assign o_rsp_valid = r_stage[LATENCY-1].valid;
    assign o_rsp_id    = r_stage[LATENCY-1].id[ID_W-1:0];
    assign o_rsp_prod  = r_stage[LATENCY-1].prod[MUL_W-1:0];
    assign o_busy      = w_busy;
    assign o_inflight  = r_inflight;

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_ready;

    logic [3:0]  ready_u,    ready_s;
    logic        rvld_u,     rvld_s;
    logic [1:0]  rid_u,      rid_s;
    logic [31:0] prod_u,     prod_s;
    logic        busy_u,     busy_s;
    logic [1:0]  infl_u,     infl_s;

    int n_cmp  = 0;
    int n_fail = 0;

    mul_share_arbiter #(
        .N_REQ(N), .IA_W(16), .IB_W(16), .MUL_W(32),
        .SIGNED(0), .APPROX_TYPE(0), .LATENCY(LAT)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid),
        .i_req_a(req_a), .i_req_b(req_b), .o_req_ready(ready_u),
        .o_rsp_valid(rvld_u), .o_rsp_id(rid_u), .o_rsp_prod(prod_u),
        .i_rsp_ready(rsp_ready), .o_busy(busy_u), .o_inflight(infl_u)
    );

    mul_share_arbiter #(
        .N_REQ(N), .IA_W(16), .IB_W(16), .MUL_W(32),
        .SIGNED(1), .APPROX_TYPE(0), .LATENCY(LAT)
    ) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid),
        .i_req_a(req_a), .i_req_b(req_b), .o_req_ready(ready_s),
        .o_rsp_valid(rvld_s), .o_rsp_id(rid_s), .o_rsp_prod(prod_s),
        .i_rsp_ready(rsp_ready), .o_busy(busy_s), .o_inflight(infl_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a fixed-length queue of result slots (front = newest).
    typedef struct {
        bit          vld;
        int          id;
        logic [15:0] a;
        logic [15:0] b;
    } ent_t;

    ent_t m_pipe[$];
    int   m_ptr;

    function automatic void model_clear();
        ent_t e;
        e.vld = 0; e.id = 0; e.a = '0; e.b = '0;
        m_pipe.delete();
        for (int i = 0; i < LAT; i++) m_pipe.push_front(e);
        m_ptr = 0;
    endfunction

    function automatic int model_pick();
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic bit model_adv();
        return !m_pipe[LAT-1].vld || rsp_ready;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        g = model_pick();
        if (rst || !model_adv() || g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    function automatic int model_inflight();
        int c;
        c = 0;
        foreach (m_pipe[i]) if (m_pipe[i].vld) c++;
        return c;
    endfunction

    function automatic logic [31:0] prod_unsigned(logic [15:0] a, logic [15:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    function automatic logic [31:0] prod_signed(logic [15:0] a, logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    task automatic model_update();
        ent_t e;
        int   g;
        if (rst) begin
            model_clear();
        end else if (model_adv()) begin
            g     = model_pick();
            e.vld = (g >= 0);
            e.id  = (g >= 0) ? g : 0;
            e.a   = (g >= 0) ? req_a[g*16 +: 16] : 16'h0;
            e.b   = (g >= 0) ? req_b[g*16 +: 16] : 16'h0;
            void'(m_pipe.pop_back());
            m_pipe.push_front(e);
            if (g >= 0) m_ptr = (g + 1) % N;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t t;
        chk("ready_u", 64'(ready_u), 64'(model_ready()));
        chk("ready_s", 64'(ready_s), 64'(model_ready()));
        if (!rst) begin
            t = m_pipe[LAT-1];
            chk("rsp_valid_u", 64'(rvld_u), 64'(t.vld));
            chk("rsp_valid_s", 64'(rvld_s), 64'(t.vld));
            chk("inflight_u",  64'(infl_u), 64'(model_inflight()));
            chk("inflight_s",  64'(infl_s), 64'(model_inflight()));
            chk("busy_u",      64'(busy_u), 64'(model_inflight() != 0));
            if (t.vld) begin
                chk("rsp_id_u", 64'(rid_u),  64'(t.id));
                chk("rsp_id_s", 64'(rid_s),  64'(t.id));
                chk("prod_u",   64'(prod_u), 64'(prod_unsigned(t.a, t.b)));
                chk("prod_s",   64'(prod_s), 64'(prod_signed(t.a, t.b)));
            end
        end
    endtask

    // Inputs are stable from the negedge; check, take the edge, advance the model.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic rand_ops();
        req_a = {$urandom(), $urandom()};
        req_b = {$urandom(), $urandom()};
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'h0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        model_clear();
        @(negedge clk);

        // Reset held with all requesters valid: nothing may be granted.
        req_valid = 4'hF;
        repeat (3) step();
        rst       = 1'b0;
        req_valid = 4'h0;
        #1;
        chk("post_rst_valid",    64'(rvld_u), 64'd0);
        chk("post_rst_inflight", 64'(infl_u), 64'd0);
        chk("post_rst_id",       64'(rid_u),  64'd0);
        chk("post_rst_prod",     64'(prod_u), 64'd0);
        chk("post_rst_busy",     64'(busy_u), 64'd0);
        step();

        // Single request from requester 1: 7*9 after two cycles.
        req_valid = 4'b0010;
        req_a[16 +: 16] = 16'd7;
        req_b[16 +: 16] = 16'd9;
        #1;
        chk("single_ready", 64'(ready_u), 64'h2);
        step();
        req_valid = 4'h0;
        step();
        #1;
        chk("single_valid", 64'(rvld_u), 64'd1);
        chk("single_id",    64'(rid_u),  64'd1);
        chk("single_prod",  64'(prod_u), 64'd63);
        step();
        repeat (2) step();

        // All requesters streaming with the consumer always ready.
        req_valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            step();
        end

        // Consumer stalls for three cycles mid-stream.
        rsp_ready = 1'b0;
        #1;
        chk("stall_inflight", 64'(infl_u), 64'd2);
        chk("stall_ready",    64'(ready_u), 64'd0);
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            step();
        end

        // Single requester always valid is granted every cycle.
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            step();
        end
        req_valid = 4'h0;
        repeat (3) step();

        // Signed: -3 * 5 from requester 2.
        req_valid = 4'b0100;
        req_a[32 +: 16] = 16'hFFFD;
        req_b[32 +: 16] = 16'd5;
        step();
        req_valid = 4'h0;
        step();
        #1;
        chk("signed_id",     64'(rid_s),  64'd2);
        chk("signed_prod",   64'(prod_s), 64'hFFFF_FFF1);
        chk("unsigned_prod", 64'(prod_u), 64'h0004_FFF1);
        step();

        // Reset with two results in flight: they vanish and the pointer returns to 0.
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step();
        end
        #1;
        chk("pre_reset_inflight", 64'(infl_u), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(rvld_u),  64'd0);
        chk("midrst_grant", 64'(ready_u), 64'h1);
        step();

        // Random traffic with random backpressure and occasional resets.
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            rand_ops();
            step();
        end
        rst = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
